// File: rtl/serial_link_pkg.sv
// Shared definitions for the single-pin serial link (transmit and receive sides).
package serial_link_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } link_state_t;

    localparam logic LINE_IDLE   = 1'b1;
    localparam logic START_LEVEL = 1'b0;
    localparam int   CNT_W       = 24;

endpackage

// File: rtl/serial_frame_tx_bit_tick_gen.sv
// Bit-period timer: counts enabled clocks while a frame is active and flags the
// last clock of each bit period.
module bit_tick_gen #(
    parameter logic [23:0] CLKS_PER_BIT = 24'd10_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic active,
    input  logic clear,
    output logic tick
);

    logic [23:0] cnt;
    logic        at_end;

    assign at_end = (cnt == CLKS_PER_BIT - 24'd1);
    assign tick   = en && active && !clear && at_end;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (en && active) begin
            cnt <= at_end ? 24'd0 : cnt + 24'd1;
        end
    end

endmodule

// File: rtl/serial_frame_tx.sv
// Frame transmitter: start bit, DATA_BITS payload bits LSB-first, stop bit.
//   state    | meaning
//   ST_IDLE  | line high, waiting for send
//   ST_START | start bit (line low) for one bit period
//   ST_DATA  | payload bit bit_idx on the line
//   ST_STOP  | stop bit (line high) for one bit period
module serial_frame_tx #(
    parameter logic [23:0] CLKS_PER_BIT = 24'd10_000_000,
    parameter int          DATA_BITS    = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [7:0] data_in,
    input  logic       send,
    output logic       tx_out,
    output logic       busy,
    output logic       done,
    output logic [3:0] bit_idx
);
    import serial_link_pkg::*;

    localparam logic [3:0] LAST_IDX = 4'(DATA_BITS - 1);

    link_state_t state, state_nxt;
    logic [7:0]  shift_r, shift_nxt;
    logic        tx_nxt, busy_nxt, done_nxt;
    logic [3:0]  idx_nxt;
    logic        start_frame;
    logic        tick;

    assign start_frame = (state == ST_IDLE) && en && send;

    bit_tick_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tick (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .active(state != ST_IDLE),
        .clear (start_frame),
        .tick  (tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            shift_r <= '0;
            tx_out  <= LINE_IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            bit_idx <= '0;
        end else begin
            state   <= state_nxt;
            shift_r <= shift_nxt;
            tx_out  <= tx_nxt;
            busy    <= busy_nxt;
            done    <= done_nxt;
            bit_idx <= idx_nxt;
        end
    end

    // done drops whenever en is low; a STOP tick cannot occur then, so the pulse waits.
    always_comb begin
        state_nxt = state;
        shift_nxt = shift_r;
        tx_nxt    = tx_out;
        busy_nxt  = busy;
        done_nxt  = 1'b0;
        idx_nxt   = bit_idx;
        if (en) begin
            case (state)
                ST_IDLE: begin
                    tx_nxt = LINE_IDLE;
                    if (send) begin
                        state_nxt = ST_START;
                        shift_nxt = data_in;
                        tx_nxt    = START_LEVEL;
                        busy_nxt  = 1'b1;
                        idx_nxt   = '0;
                    end
                end
                ST_START: begin
                    if (tick) begin
                        state_nxt = ST_DATA;
                        tx_nxt    = shift_r[0];
                        idx_nxt   = '0;
                    end
                end
                ST_DATA: begin
                    if (tick) begin
                        if (bit_idx == LAST_IDX) begin
                            state_nxt = ST_STOP;
                            tx_nxt    = LINE_IDLE;
                            idx_nxt   = '0;
                        end else begin
                            shift_nxt = {1'b0, shift_r[7:1]};
                            tx_nxt    = shift_r[1];
                            idx_nxt   = bit_idx + 4'd1;
                        end
                    end
                end
                ST_STOP: begin
                    if (tick) begin
                        state_nxt = ST_IDLE;
                        busy_nxt  = 1'b0;
                        done_nxt  = 1'b1;
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_frame_tx.sv
// Bench for serial_frame_tx: table-driven frames plus hand-written corner cases,
// checked cycle by cycle against a queue of expected output records.
module tb_serial_frame_tx;

    typedef struct {
        logic       tx;
        logic       busy;
        logic       done;
        logic [3:0] idx;
    } exp_t;

    typedef struct {
        logic [7:0] data;
        logic [9:0] line;
        string      name;
    } vec_t;

    logic       clk;
    logic       rst;
    logic       en_a, send_a, en_b, send_b;
    logic [7:0] data_a, data_b;
    logic       tx_a, busy_a, done_a, tx_b, busy_b, done_b;
    logic [3:0] idx_a, idx_b;

    exp_t q_a[$];
    exp_t q_b[$];
    vec_t vecs[5];
    int   checks = 0;
    int   errors = 0;

    serial_frame_tx #(.CLKS_PER_BIT(24'd4), .DATA_BITS(8)) dut_a (
        .clk(clk), .rst(rst), .en(en_a), .data_in(data_a), .send(send_a),
        .tx_out(tx_a), .busy(busy_a), .done(done_a), .bit_idx(idx_a)
    );

    serial_frame_tx #(.CLKS_PER_BIT(24'd1), .DATA_BITS(5)) dut_b (
        .clk(clk), .rst(rst), .en(en_b), .data_in(data_b), .send(send_b),
        .tx_out(tx_b), .busy(busy_b), .done(done_b), .bit_idx(idx_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_rec(input int which, input exp_t e, input string name);
        exp_t a;
        if (which == 0) begin
            a.tx = tx_a; a.busy = busy_a; a.done = done_a; a.idx = idx_a;
        end else begin
            a.tx = tx_b; a.busy = busy_b; a.done = done_b; a.idx = idx_b;
        end
        checks++;
        if (a.tx !== e.tx || a.busy !== e.busy || a.done !== e.done || a.idx !== e.idx) begin
            errors++;
            $display("FAIL %s @%0t: got tx=%b busy=%b done=%b idx=%0d, want tx=%b busy=%b done=%b idx=%0d",
                     name, $time, a.tx, a.busy, a.done, a.idx, e.tx, e.busy, e.done, e.idx);
        end
    endtask

    task automatic push_rec(input int which, input exp_t e);
        if (which == 0) q_a.push_back(e);
        else            q_b.push_back(e);
    endtask

    task automatic push_idle(input int which, input int n);
        exp_t e;
        e.tx = 1'b1; e.busy = 1'b0; e.done = 1'b0; e.idx = 4'd0;
        for (int i = 0; i < n; i++) push_rec(which, e);
    endtask

    task automatic push_frame(input int which, input logic [9:0] line, input int nbits);
        exp_t e;
        int   cpb;
        cpb = (which == 0) ? 4 : 1;
        for (int b = 0; b < nbits + 2; b++) begin
            for (int k = 0; k < cpb; k++) begin
                e.tx   = line[b];
                e.busy = 1'b1;
                e.done = 1'b0;
                e.idx  = (b >= 1 && b <= nbits) ? 4'(b - 1) : 4'd0;
                push_rec(which, e);
            end
        end
        e.tx = 1'b1; e.busy = 1'b0; e.done = 1'b1; e.idx = 4'd0;
        push_rec(which, e);
    endtask

    function automatic logic [9:0] make_line(input logic [7:0] d, input int nbits);
        logic [9:0] l;
        l = '0;
        for (int i = 0; i < nbits; i++) l[i + 1] = d[i];
        l[nbits + 1] = 1'b1;
        return l;
    endfunction

    task automatic consume(input int which, input int n, input string name);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            if ((which == 0 && q_a.size() == 0) || (which == 1 && q_b.size() == 0)) begin
                checks++;
                errors++;
                $display("FAIL %s: scoreboard empty, got nothing to compare, want a record", name);
            end else begin
                e = (which == 0) ? q_a.pop_front() : q_b.pop_front();
                check_rec(which, e, name);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic run_vec(input vec_t v);
        data_a = v.data;
        send_a = 1'b1;
        push_frame(0, v.line, 8);
        push_idle(0, 1);
        @(posedge clk); #1;
        send_a = 1'b0;
        consume(0, 42, v.name);
    endtask

    initial begin
        exp_t held;
        exp_t rst_exp;
        logic [9:0] lb;

        vecs[0] = '{data: 8'hA5, line: 10'b1_1010_0101_0, name: "frame_a5"};
        vecs[1] = '{data: 8'h00, line: 10'b1_0000_0000_0, name: "frame_00"};
        vecs[2] = '{data: 8'hFF, line: 10'b1_1111_1111_0, name: "frame_ff"};
        vecs[3] = '{data: 8'h3C, line: 10'b1_0011_1100_0, name: "frame_3c"};
        vecs[4] = '{data: 8'h01, line: 10'b1_0000_0001_0, name: "frame_01"};

        rst_exp.tx = 1'b1; rst_exp.busy = 1'b0; rst_exp.done = 1'b0; rst_exp.idx = 4'd0;

        rst = 1'b1;
        en_a = 1'b1; send_a = 1'b0; data_a = 8'h00;
        en_b = 1'b1; send_b = 1'b0; data_b = 8'h00;
        #12;
        check_rec(0, rst_exp, "reset_a");
        check_rec(1, rst_exp, "reset_b");
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        check_rec(0, rst_exp, "idle_after_reset");

        for (int i = 0; i < 5; i++) run_vec(vecs[i]);

        // send held high: back-to-back frames separated by the done cycle only
        data_a = 8'h00;
        send_a = 1'b1;
        push_frame(0, vecs[1].line, 8);
        push_frame(0, vecs[1].line, 8);
        push_idle(0, 2);
        @(posedge clk); #1;
        consume(0, 41, "b2b_first");
        send_a = 1'b0;
        consume(0, 43, "b2b_second");

        // data change and send during bit 3 are ignored
        data_a = 8'hA5;
        send_a = 1'b1;
        push_frame(0, vecs[0].line, 8);
        push_idle(0, 4);
        @(posedge clk); #1;
        send_a = 1'b0;
        consume(0, 17, "midframe_pre");
        data_a = 8'hFF;
        send_a = 1'b1;
        consume(0, 1, "midframe_send");
        send_a = 1'b0;
        consume(0, 27, "midframe_post");

        // en low for 7 clocks inside bit 5
        data_a = 8'hA5;
        send_a = 1'b1;
        push_frame(0, vecs[0].line, 8);
        push_idle(0, 2);
        @(posedge clk); #1;
        send_a = 1'b0;
        consume(0, 25, "pause_pre");
        held = q_a[0];
        en_a = 1'b0;
        for (int i = 0; i < 7; i++) begin
            @(posedge clk); #1;
            check_rec(0, held, "pause_frozen");
        end
        en_a = 1'b1;
        consume(0, 18, "pause_post");

        // asynchronous reset in the middle of bit 2
        data_a = 8'hA5;
        send_a = 1'b1;
        push_frame(0, vecs[0].line, 8);
        @(posedge clk); #1;
        send_a = 1'b0;
        consume(0, 13, "abort_pre");
        q_a.delete();
        #2 rst = 1'b1;
        #1 check_rec(0, rst_exp, "abort_async");
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        check_rec(0, rst_exp, "abort_idle");
        run_vec(vecs[3]);

        // one clock per bit, five payload bits
        lb = make_line(8'h13, 5);
        data_b = 8'h13;
        send_b = 1'b1;
        push_frame(1, lb, 5);
        push_idle(1, 2);
        @(posedge clk); #1;
        send_b = 1'b0;
        consume(1, 10, "cpb1_13");

        // one clock per bit, send held: back-to-back short frames
        lb = make_line(8'h0A, 5);
        data_b = 8'h0A;
        send_b = 1'b1;
        push_frame(1, lb, 5);
        push_frame(1, lb, 5);
        push_idle(1, 2);
        @(posedge clk); #1;
        consume(1, 8, "cpb1_b2b_first");
        send_b = 1'b0;
        consume(1, 10, "cpb1_b2b_second");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
